stream_fork: RTL and testbench
==============================

Name: stream_fork

Overview:
- Fan-out counterpart of the adder-tree reduction. Takes one valid/ready stream and broadcasts each beat to OUT_SIZE independent valid/ready consumers.
- Each consumer may accept its copy of the beat in any cycle.
- The input beat retires only after every consumer has taken its copy.
- Sits in front of parallel compute lanes, e.g. feeding a shared activation to several dot-product units whose partial results later meet in an adder tree.

Parameters:
- OUT_SIZE, 4: number of output ports; must be at least 1.
- DATA_WIDTH, 32: width of the data word; passed through unchanged to every output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low (asserted when 0).
- data_in  input  DATA_WIDTH  input beat.
- data_in_valid  input  1  input beat valid.
- data_in_ready  output  1  input beat accepted this cycle when high together with data_in_valid.
- data_out  output  DATA_WIDTH x OUT_SIZE (unpacked array [OUT_SIZE-1:0])  per-consumer copy of the beat.
- data_out_valid  output  OUT_SIZE  per-consumer valid.
- data_out_ready  input  OUT_SIZE  per-consumer ready.

Behaviour:
- State: sent[OUT_SIZE-1:0], where sent[j]=1 means consumer j has already taken the current input beat.
- Reset: sent is cleared to all zeros asynchronously. While reset is asserted, data_out_valid=0 and data_in_ready=0. Any beat in flight is dropped.
- Output valid: data_out_valid[j] = data_in_valid & ~sent[j]. data_out[j] = data_in for all j.
- Per-consumer transfer: fire[j] = data_out_valid[j] & data_out_ready[j].
- Input ready: data_in_ready = &(sent | data_out_ready). The input is accepted in the cycle where every consumer has either taken the beat earlier or is taking it now.
- Next-state rule:
  - If data_in_valid & data_in_ready, then sent <= 0 (beat retires).
  - Else sent <= sent | fire.
- Latency: 0 cycles (combinational path) in the base build.
- Throughput: 1 beat/cycle when all readies are high.
- No beat is duplicated to a consumer. A consumer with sent[j]=1 sees valid low until the next beat.
- Simultaneous events: if the last missing consumers fire in the same cycle that completes the set, the beat retires that cycle. The next beat may present on the following cycle with sent all zero.
- data_in_valid dropping while sent!=0 is a protocol violation by the producer. sent is held, and no requirement applies to the outputs.
- data_in must stay stable while data_in_valid=1 and the beat has not retired.
- OUT_SIZE=1 degenerates to a wire: data_in_ready = data_out_ready[0].
- No combinational path from data_in_valid to data_in_ready.

Optional Feature:
- Macro: STREAM_FORK_OUTPUT_REG_EN.
- Defined:
  - Each output gets a one-entry register holding data and valid; data_out and data_out_valid are driven from flops.
  - data_in_ready = &(~buf_valid | data_out_ready). Each buffer either is empty or drains this cycle.
  - On input accept, all buffers load data_in with valid=1. A buffer clears when it fires and no new load occurs.
  - Latency 1 cycle. Full throughput is kept when all consumers are ready.
  - No combinational path from data_out_ready to data_out_valid. sent is unused.
  - Reset clears all buf_valid.
- Undefined: combinational behaviour as described above.

Test Plan:
- All readies high, data_in 0x11,0x22,0x33 on consecutive cycles -> each data_out[j] shows 0x11,0x22,0x33 on the same cycles; data_in_ready=1 every cycle.
- OUT_SIZE=4, beat 0xAA, readies asserted one per cycle for j=0..3 -> each valid[j] drops after its fire; data_in_ready=1 only in the cycle j=3 fires; next beat 0xBB appears with all four valids high.
- Beat 0xCC, ready[0] and ready[2] high in cycle 0, ready[1] and ready[3] high in cycle 2 -> valid[0] and valid[2] low in cycles 1-2; beat retires in cycle 2; no consumer receives 0xCC twice.
- Assert rst=0 mid-beat with sent=4'b0101 -> valids and data_in_ready go low immediately; after release, the same beat is re-offered to all four consumers.
- Random per-consumer ready backpressure (50%), 1000 beats -> every consumer receives the exact input sequence in order with no loss or duplicates.
- With STREAM_FORK_OUTPUT_REG_EN, all readies high, beats 1,2,3 -> outputs show 1,2,3 one cycle later, back-to-back.

Source files
------------

// File: rtl/stream_fork.sv
// stream_fork: broadcast one valid/ready stream to OUT_SIZE consumers; define STREAM_FORK_OUTPUT_REG_EN for registered outputs
module stream_fork #(
   parameter int OUT_SIZE   = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_in_valid,
   output logic                  data_in_ready,
   output logic [DATA_WIDTH-1:0] data_out [OUT_SIZE-1:0],
   output logic [OUT_SIZE-1:0]   data_out_valid,
   input  logic [OUT_SIZE-1:0]   data_out_ready
);
   logic accept;
`ifdef STREAM_FORK_OUTPUT_REG_EN
   logic [OUT_SIZE-1:0]   buf_valid;
   logic [DATA_WIDTH-1:0] buf_data;
   // every buffer loads together, so one data register serves all outputs
   assign data_in_ready  = rst & (&(~buf_valid | data_out_ready));
   assign accept         = data_in_valid & data_in_ready;
   assign data_out_valid = buf_valid;
   always_ff @(posedge clk or negedge rst)
      if (!rst) buf_valid <= '0;
      else buf_valid <= accept ? '1 : buf_valid & ~data_out_ready;
   always_ff @(posedge clk)
      if (accept) buf_data <= data_in;
   for (genvar g = 0; g < OUT_SIZE; g++) begin : g_out
      assign data_out[g] = buf_data;
   end
`else
   logic [OUT_SIZE-1:0] sent;
   assign data_in_ready  = rst & (&(sent | data_out_ready));
   assign accept         = data_in_valid & data_in_ready;
   assign data_out_valid = {OUT_SIZE{data_in_valid & rst}} & ~sent;
   always_ff @(posedge clk or negedge rst)
      if (!rst) sent <= '0;
      else sent <= accept ? '0 : sent | (data_out_valid & data_out_ready);
   for (genvar g = 0; g < OUT_SIZE; g++) begin : g_out
      assign data_out[g] = data_in;
   end
`endif
endmodule

// File: tb/tb_stream_fork.sv
// tb_stream_fork: vector table plus scoreboard bench for stream_fork (both STREAM_FORK_OUTPUT_REG_EN builds)
module tb_stream_fork;
   localparam int N = 4;
   localparam int NB = 1000;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_in;
   logic        data_in_valid;
   logic        data_in_ready;
   logic [31:0] data_out [N-1:0];
   logic [N-1:0] data_out_valid;
   logic [N-1:0] data_out_ready;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic [31:0] din;
      logic        vin;
      logic [3:0]  rdy;
      logic [3:0]  e_vout;
      logic        e_irdy;
   } vec_t;
   vec_t vecs[$];
   logic [31:0] exp_q[$];
   int rd [N];

   stream_fork #(.OUT_SIZE(N), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready), .data_out(data_out),
      .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] r);
      data_in_valid = v;
      data_in = d;
      data_out_ready = r;
   endtask

   // checks any output transfers against the scoreboard and advances per-consumer read pointers
   task automatic score();
      for (int j = 0; j < N; j++)
         if (data_out_valid[j] && data_out_ready[j]) begin
            if (rd[j] >= exp_q.size()) begin
               checks++;
               errors++;
               $display("FAIL sb_extra consumer %0d got %h expected nothing", j, data_out[j]);
            end else chk($sformatf("sb_c%0d_b%0d", j, rd[j]), data_out[j], exp_q[rd[j]]);
            rd[j]++;
         end
   endtask

   initial begin
      int k, cyc;
      logic pushed;
      rst = 1'b0;
      drive(1'b1, 32'h5A, 4'hF);
      #2;
      chk("rst_valid", 32'(data_out_valid), 32'h0);
      chk("rst_ready", 32'(data_in_ready), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
`ifndef STREAM_FORK_OUTPUT_REG_EN
      vecs.push_back(vec_t'{1'b1, 32'h11, 1'b1, 4'hF, 4'hF, 1'b1});
      vecs.push_back(vec_t'{1'b1, 32'h22, 1'b1, 4'hF, 4'hF, 1'b1});
      vecs.push_back(vec_t'{1'b1, 32'h33, 1'b1, 4'hF, 4'hF, 1'b1});
      vecs.push_back(vec_t'{1'b1, 32'hAA, 1'b1, 4'h1, 4'hF, 1'b0});
      vecs.push_back(vec_t'{1'b1, 32'hAA, 1'b1, 4'h2, 4'hE, 1'b0});
      vecs.push_back(vec_t'{1'b1, 32'hAA, 1'b1, 4'h4, 4'hC, 1'b0});
      vecs.push_back(vec_t'{1'b1, 32'hAA, 1'b1, 4'h8, 4'h8, 1'b1});
      vecs.push_back(vec_t'{1'b1, 32'hBB, 1'b1, 4'h0, 4'hF, 1'b0});
      vecs.push_back(vec_t'{1'b1, 32'hBB, 1'b1, 4'hF, 4'hF, 1'b1});
      vecs.push_back(vec_t'{1'b1, 32'hCC, 1'b1, 4'h5, 4'hF, 1'b0});
      vecs.push_back(vec_t'{1'b1, 32'hCC, 1'b1, 4'h0, 4'hA, 1'b0});
      vecs.push_back(vec_t'{1'b1, 32'hCC, 1'b1, 4'hA, 4'hA, 1'b1});
      vecs.push_back(vec_t'{1'b1, 32'h00, 1'b0, 4'hF, 4'h0, 1'b1});
      vecs.push_back(vec_t'{1'b1, 32'h00, 1'b0, 4'h0, 4'h0, 1'b0});
      vecs.push_back(vec_t'{1'b1, 32'hDD, 1'b1, 4'h5, 4'hF, 1'b0});
      vecs.push_back(vec_t'{1'b0, 32'hDD, 1'b1, 4'hF, 4'h0, 1'b0});
      vecs.push_back(vec_t'{1'b1, 32'hDD, 1'b1, 4'h0, 4'hF, 1'b0});
      vecs.push_back(vec_t'{1'b1, 32'hDD, 1'b1, 4'hF, 4'hF, 1'b1});
      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         drive(vecs[i].vin, vecs[i].din, vecs[i].rdy);
         #4;
         chk($sformatf("v%0d_valid", i), 32'(data_out_valid), 32'(vecs[i].e_vout));
         chk($sformatf("v%0d_ready", i), 32'(data_in_ready), 32'(vecs[i].e_irdy));
         for (int j = 0; j < N; j++) chk($sformatf("v%0d_data%0d", i, j), data_out[j], vecs[i].din);
         @(posedge clk);
         #1;
      end
`else
      for (int c = 0; c < 5; c++) begin
         drive(c < 3, 32'(c + 1), 4'hF);
         #4;
         chk($sformatf("reg_c%0d_valid", c), 32'(data_out_valid), (c >= 1 && c <= 3) ? 32'hF : 32'h0);
         chk($sformatf("reg_c%0d_ready", c), 32'(data_in_ready), 32'h1);
         if (c >= 1 && c <= 3)
            for (int j = 0; j < N; j++) chk($sformatf("reg_c%0d_data%0d", c, j), data_out[j], 32'(c));
         @(posedge clk);
         #1;
      end
`endif
      k = 0;
      cyc = 0;
      pushed = 1'b0;
      for (int j = 0; j < N; j++) rd[j] = 0;
      while (k < NB && cyc < 20000) begin
         drive(pushed ? 1'b1 : ($urandom_range(3) != 0), 32'($urandom), 4'($urandom));
         if (pushed) data_in = exp_q[k];
         if (data_in_valid && !pushed) begin
            exp_q.push_back(data_in);
            pushed = 1'b1;
         end
         #4;
         score();
         if (data_in_valid && data_in_ready) begin
            k++;
            pushed = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("rand_beats_accepted", 32'(k), 32'(NB));
      cyc = 0;
      while ((rd[0] < exp_q.size() || rd[1] < exp_q.size() || rd[2] < exp_q.size() ||
              rd[3] < exp_q.size()) && cyc < 100) begin
         drive(1'b0, 32'h0, 4'($urandom));
         #4;
         score();
         @(posedge clk);
         #1;
         cyc++;
      end
      for (int j = 0; j < N; j++) chk($sformatf("rand_count_c%0d", j), 32'(rd[j]), 32'(NB));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
